// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first ripple through one full adder, WIDTH cycles per addition.
// Result and carry-out are registered and change only when an addition completes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_a_q, shreg_a_d;
    logic [WIDTH-1:0] shreg_b_q, shreg_b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_s, fa_co;

    always_comb begin
        state_d   = state_q;
        shreg_a_d = shreg_a_q;
        shreg_b_d = shreg_b_q;
        psum_d    = psum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        fa_s      = shreg_a_q[0] ^ shreg_b_q[0] ^ carry_q;
        fa_co     = (shreg_a_q[0] & shreg_b_q[0]) | ((shreg_a_q[0] ^ shreg_b_q[0]) & carry_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts start directly so back-to-back additions lose no cycle.
                if (start) begin
                    shreg_a_d = a;
                    shreg_b_d = b;
                    carry_d   = cin;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                shreg_a_d = {1'b0, shreg_a_q[WIDTH-1:1]};
                shreg_b_d = {1'b0, shreg_b_q[WIDTH-1:1]};
                psum_d    = {fa_s, psum_q[WIDTH-1:1]};
                carry_d   = fa_co;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_s, psum_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_a_q <= '0;
            shreg_b_q <= '0;
            psum_q    <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_a_q <= shreg_a_d;
            shreg_b_q <= shreg_b_d;
            psum_q    <= psum_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: one 8-bit and one 16-bit instance sharing clock and reset,
// directed vectors, multi-cycle corner sequences and randomised checks against a + b + cin.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        cin_in = 1'b0;

    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic [1:0]  dbg8;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;
    logic [1:0]  dbg16;

    int n_pass = 0;
    int n_total = 0;
    logic [16:0] held8 = '0;
    logic [16:0] held16 = '0;
    logic [16:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs[7];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .dbg_state(dbg8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a_in), .b(b_in), .cin(cin_in),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .dbg_state(dbg16)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic w_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic w_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    function automatic logic [16:0] w_res(input int w);
        return (w == 8) ? {8'b0, cout8, sum8} : {cout16, sum16};
    endfunction

    // Driver: called at posedge+1; start is presented for the next edge.
    // Returns at posedge+1 of the done cycle.
    task automatic do_add(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [16:0] exp, input string name);
        int cyc;
        bit run_ok;
        logic [16:0] held;
        held = (w == 8) ? held8 : held16;
        exp_q.push_back(exp);
        a_in = a;
        b_in = b;
        cin_in = c;
        if (w == 8) start8 = 1'b1; else start16 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        start16 = 1'b0;
        cyc = 1;
        run_ok = 1'b1;
        while (!w_done(w) && cyc <= 40) begin
            if (!w_busy(w) || w_res(w) !== held) run_ok = 1'b0;
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            cin_in = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " busy/held during run"}, 32'(run_ok), 32'd1);
        check({name, " start-to-done spacing"}, 32'(cyc), 32'(w + 1));
        check({name, " busy low at done"}, 32'(w_busy(w)), 32'd0);
        check({name, " result"}, 32'(w_res(w)), 32'(exp_q.pop_front()));
        if (w == 8) held8 = exp; else held16 = exp;
    endtask

    initial begin
        int cyc;
        int extra_done;
        bit held_ok;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] model;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, exp: 9'h096};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp: 9'h100};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp: 9'h1FF};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, exp: 9'h000};
        vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, exp: 9'h001};
        vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp: 9'h100};
        vecs[6] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, exp: 9'h080};

        // Reset state, before any clock edge.
        #1;
        check("reset outputs w8", {busy8, done8, cout8, sum8}, 32'd0);
        check("reset outputs w16", {busy16, done16, cout16, sum16}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors; each after the first is started in the previous DONE cycle.
        for (int i = 0; i < 7; i++)
            do_add(8, {8'b0, vecs[i].a}, {8'b0, vecs[i].b}, vecs[i].cin,
                   {8'b0, vecs[i].exp}, $sformatf("vec%0d", i));

        // Back-to-back with start held during DONE; previous 0x080 must hold until completion.
        do_add(8, 16'h0001, 16'h0002, 1'b1, 17'h004, "back_to_back");
        @(posedge clk); #1;
        check("idle after done", {busy8, done8}, 32'd0);

        // Start ignored while running.
        a_in = 16'h0010; b_in = 16'h0020; cin_in = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc <= 40) begin
            start8 = (cyc == 3);
            if (cyc == 3) begin
                a_in = 16'h00AA;
                b_in = 16'h0055;
                cin_in = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start8 = 1'b0;
        check("ignored start spacing", 32'(cyc), 32'd9);
        check("ignored start result", {cout8, sum8}, 32'h030);
        extra_done = 0;
        held_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) extra_done++;
            if ({cout8, sum8} !== 9'h030) held_ok = 1'b0;
        end
        check("ignored start single done", 32'(extra_done), 32'd0);
        check("result held in idle", 32'(held_ok), 32'd1);
        held8 = 17'h030;

        // Asynchronous reset mid-run of 0x7F+0x01.
        a_in = 16'h007F; b_in = 16'h0001; cin_in = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre-reset busy", 32'(busy8), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset outputs", {busy8, done8, cout8, sum8}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        held8 = '0;
        held16 = '0;
        check("post-reset outputs", {busy8, done8, cout8, sum8}, 32'd0);
        do_add(8, 16'h0033, 16'h0044, 1'b0, 17'h077, "after_reset");

        // Randomised: reference model is plain arithmetic truncated to WIDTH+1 bits.
        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w = (wi == 0) ? 8 : 16;
            for (int n = 0; n < 1000; n++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                if ($urandom_range(0, 9) == 0) ra = 16'hFFFF;
                if ($urandom_range(0, 9) == 0) rb = 16'hFFFF;
                if (w == 8) begin
                    ra = ra & 16'h00FF;
                    rb = rb & 16'h00FF;
                end
                model = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
                if (w == 8) model = model & 17'h001FF;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                do_add(w, ra, rb, rc, model, $sformatf("rand w%0d #%0d", w, n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
